// File: rtl/debounce_pkg.sv
// Shared types and defaults for the switch debouncer.
// Holds the channel FSM encoding and the default qualification length.
package debounce_pkg;

  localparam int unsigned DEBOUNCE_CYCLES_DFLT = 1_000_000;

  typedef enum logic [1:0] {
    ST_STABLE_LO,
    ST_WAIT_HI,
    ST_STABLE_HI,
    ST_WAIT_LO
  } state_e;

endpackage

// File: rtl/debounce_channel.sv
// One debounced input bit: 2-FF synchronizer, qualification FSM,
// stability counter and registered level / edge strobes.
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DFLT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw_in,
  output logic level_out,
  output logic rise_pulse,
  output logic fall_pulse
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  logic          r_sync1;
  logic          r_sync2;
  state_e        r_state;
  logic [CW-1:0] r_cnt;
  logic          r_level;
  logic          r_rise;
  logic          r_fall;

  state_e        w_state_nx;
  logic [CW-1:0] w_cnt_nx;
  logic          w_level_nx;
  logic          w_rise_nx;
  logic          w_fall_nx;

  // Bring the asynchronous switch level into the clock domain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= raw_in;
      r_sync2 <= r_sync1;
    end
  end

  // Qualify a new level; any bounce in a wait state restarts from zero.
  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_level_nx = r_level;
    w_rise_nx  = 1'b0;
    w_fall_nx  = 1'b0;
    unique case (r_state)
      ST_STABLE_LO: begin
        if (r_sync2) begin
          w_state_nx = ST_WAIT_HI;
          w_cnt_nx   = ONE;
        end
      end
      ST_WAIT_HI: begin
        if (!r_sync2) begin
          w_state_nx = ST_STABLE_LO;
          w_cnt_nx   = '0;
        end else if (r_cnt == LAST) begin
          w_state_nx = ST_STABLE_HI;
          w_cnt_nx   = '0;
          w_level_nx = 1'b1;
          w_rise_nx  = 1'b1;
        end else begin
          w_cnt_nx = r_cnt + ONE;
        end
      end
      ST_STABLE_HI: begin
        if (!r_sync2) begin
          w_state_nx = ST_WAIT_LO;
          w_cnt_nx   = ONE;
        end
      end
      ST_WAIT_LO: begin
        if (r_sync2) begin
          w_state_nx = ST_STABLE_HI;
          w_cnt_nx   = '0;
        end else if (r_cnt == LAST) begin
          w_state_nx = ST_STABLE_LO;
          w_cnt_nx   = '0;
          w_level_nx = 1'b0;
          w_fall_nx  = 1'b1;
        end else begin
          w_cnt_nx = r_cnt + ONE;
        end
      end
    endcase
  end

  // Register FSM state, counter and all outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_STABLE_LO;
      r_cnt   <= '0;
      r_level <= 1'b0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
      r_level <= w_level_nx;
      r_rise  <= w_rise_nx;
      r_fall  <= w_fall_nx;
    end
  end

  assign level_out  = r_level;
  assign rise_pulse = r_rise;
  assign fall_pulse = r_fall;

endmodule

// File: rtl/switch_debouncer.sv
// Multi-channel switch debouncer: WIDTH independent channels
// producing clean levels plus single-cycle rise/fall strobes.
module switch_debouncer
  import debounce_pkg::*;
#(
  parameter int unsigned WIDTH           = 2,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DFLT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] raw_in,
  output logic [WIDTH-1:0] level_out,
  output logic [WIDTH-1:0] rise_pulse,
  output logic [WIDTH-1:0] fall_pulse
);

  genvar g;
  generate
    for (g = 0; g < WIDTH; g++) begin : g_ch
      debounce_channel #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
      ) u_ch (
        .clk        (clk),
        .rst_n      (rst_n),
        .raw_in     (raw_in[g]),
        .level_out  (level_out[g]),
        .rise_pulse (rise_pulse[g]),
        .fall_pulse (fall_pulse[g])
      );
    end
  endgenerate

endmodule
